bus_cycle_initiator: RTL and testbench
======================================

// Module: bus_cycle_initiator
// PURPOSE
//  8086-style bus master. Turns single-beat requests from the CPU core into T1-T4 bus cycles.
//  It drives ALE, RD, WR, IOM and Address, drives write data, and captures read data.
//  It is the initiating end of the bus that the memory/IO responders decode.
//  It sits between the core's request port and the shared system bus.
// PARAMETERS
//  ADDR_W    20  address width (1 MB space)
//  DATA_W    8   data width
//  MAX_WAIT  15  wait states tolerated in TW before the cycle is aborted with an error
// PORTS
//  CLK        in   1       bus clock, all state on posedge
//  RESET      in   1       asynchronous, active-high reset
//  req_valid  in   1       core request valid
//  req_ready  out  1       initiator can accept a request this cycle
//  req_write  in   1       1 = write cycle, 0 = read cycle
//  req_io     in   1       1 = IO space, 0 = memory space
//  req_addr   in   ADDR_W  request address
//  req_wdata  in   DATA_W  write data
//  resp_valid out  1       one-cycle pulse: cycle complete
//  resp_rdata out  DATA_W  read data, valid with resp_valid on reads
//  resp_err   out  1       wait-state timeout; valid with resp_valid
//  ALE        out  1       address latch enable, high during T1 only
//  RD         out  1       read strobe, active-low
//  WR         out  1       write strobe, active-low
//  IOM        out  1       1 = memory cycle, 0 = IO cycle
//  Address    out  ADDR_W  latched cycle address
//  Data_out   out  DATA_W  write data to the bus
//  Data_oe    out  1       enable for the Data tristate buffer (write T2-T4)
//  Data_in    in   DATA_W  bus data from the responder
//  READY      in   1       responder ready, sampled in T3/TW
// BEHAVIOUR
//  - Reset (async): state=IDLE, ALE=0, RD=1, WR=1, IOM=0, Address=0, Data_out=0, Data_oe=0,
//    req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
//  - Reset mid-cycle: strobes deassert immediately; no resp_valid for the aborted request.
//  - FSM states IDLE, T1, T2, T3, TW, T4, one-hot, typedef'd enum.
//  - Handshake: accept when req_valid & req_ready. Address, write, io and wdata are latched then.
//  - req_ready=1 in IDLE and in T4 only; otherwise 0. Core must hold its request until accepted.
//  - IDLE --accept--> T1.
//  - T1: ALE=1, Address and IOM (=~req_io) driven and held until the next T1.
//  - T2: ALE=0. Read: RD=0. Write: WR=0, Data_oe=1, Data_out=wdata.
//  - T3: strobes held. Next is T4 if READY=1 (or READY is ignored, see CONFIGURATION); else TW.
//  - TW: strobes held; wait counter increments each cycle.
//    READY=1 -> T4. Counter==MAX_WAIT with READY=0 -> T4 with err flagged.
//  - Read data: Data_in is captured on the clock edge that leaves T3/TW into resp_rdata.
//  - T4: RD=1, WR=1; Data_oe stays 1 for writes (hold time) and drops on exit.
//    resp_valid=1 for exactly this cycle; resp_err=timeout flag; wait counter cleared.
//  - T4 exit: accept -> T1 (back-to-back, 4 cycles/transaction min); else IDLE.
//  - Latency: accept edge -> resp_valid = 4 cycles + wait states.
//  - RD and WR are never low together; ALE is never high while RD or WR is low.
// CONFIGURATION
//  - WAIT_STATE_EN defined: READY is sampled, TW is inserted, timeout/resp_err are active.
//  - Undefined: READY is ignored, T3 always goes to T4, and TW is unreachable.
//    The wait counter is not built and resp_err is tied to 0.
// STRUCTURE
//  - bus_pkg: bus_state_t enum (IDLE,T1,T2,T3,TW,T4) and the strobe-level constants
//    STROBE_ON=1'b0, STROBE_OFF=1'b1.
//  - Single module; the wait counter is inline, no sub-module.
// TESTING
//  1. Read mem 20'h0_1234, responder returns 8'hA5, READY=1 -> ALE in T1, RD low T2-T3,
//     IOM=1, resp_valid 4 cycles after accept, rdata=8'hA5, err=0.
//  2. Write IO 20'h0_0040 data 8'h3C -> IOM=0, WR low T2-T3, Data_oe=1 T2-T4, Data_out=8'h3C,
//     resp_valid in T4.
//  3. WAIT_STATE_EN, READY low for 3 cycles -> exactly 3 TW cycles, latency 7, data captured
//     after READY rises.
//  4. WAIT_STATE_EN, READY held low -> 15 TW cycles, then T4 with resp_valid=1, resp_err=1;
//     next request runs err=0.
//  5. Back-to-back: req_valid held for two reads -> second T1 follows T4 directly, no IDLE,
//     ALE pulses 4 cycles apart.
//  6. RESET asserted in T2 of a write -> same-cycle WR=1, Data_oe=0, ALE=0; after release,
//     IDLE, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the 8086-style bus cycle initiator.
package bus_pkg;

  // One-hot bus cycle phases.
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    TW   = 6'b010000,
    T4   = 6'b100000
  } bus_state_t;

  // RD/WR are active-low bus strobes.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/bus_cycle_initiator.sv
// 8086-style bus master: turns single-beat core requests into T1-T4 bus cycles.
// Optional feature macro: WAIT_STATE_EN (READY sampling, TW insertion, timeout error).
// Without it READY is ignored, T3 always proceeds to T4 and resp_err is tied low.
module bus_cycle_initiator
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              IOM,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              READY
);

  bus_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;
  logic              iom_q, iom_d;
  logic              accept;
  logic              strobe_phase;

`ifdef WAIT_STATE_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
`else
  // READY and the timeout limit have no effect in this build.
  logic              unused_cfg;
  assign unused_cfg = READY | (MAX_WAIT == 0);
`endif

  // State and latched cycle attributes; everything returns to idle on reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      iom_q      <= 1'b0;
`ifdef WAIT_STATE_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      write_q    <= write_d;
      iom_q      <= iom_d;
`ifdef WAIT_STATE_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state logic: phase sequencing, request latching and read-data capture.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    iom_d   = iom_q;
`ifdef WAIT_STATE_EN
    err_d   = err_q;
`endif

    req_ready = (state_q == IDLE) || (state_q == T4);
    accept    = req_valid && req_ready;

    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      write_d = req_write;
      iom_d   = ~req_io;
`ifdef WAIT_STATE_EN
      err_d   = 1'b0;
`endif
    end

    case (state_q)
      IDLE: if (accept) state_d = T1;
      T1:   state_d = T2;
      T2:   state_d = T3;
      T3: begin
`ifdef WAIT_STATE_EN
        state_d = READY ? T4 : TW;
`else
        state_d = T4;
`endif
      end
      TW: begin
`ifdef WAIT_STATE_EN
        if (READY) begin
          state_d = T4;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
          state_d = T4;
          err_d   = 1'b1;
        end
`else
        state_d = T4;
`endif
      end
      T4:      state_d = accept ? T1 : IDLE;
      default: state_d = IDLE;
    endcase

    // Read data is taken on the edge that closes the data phase.
    if ((state_q == T3 || state_q == TW) && state_d == T4 && !write_q) begin
      rdata_d = Data_in;
    end
  end

`ifdef WAIT_STATE_EN
  // Wait counter: counts TW cycles of the current transfer, cleared in T4.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d == TW) begin
      wait_cnt_d = CNT_W'(wait_cnt_q + 1'b1);
    end else if (state_q == T4) begin
      wait_cnt_d = '0;
    end
  end
`endif

  // Bus pins decoded from the current phase; reset forces IDLE so strobes drop at once.
  always_comb begin
    strobe_phase = (state_q == T2) || (state_q == T3) || (state_q == TW);
    ALE          = (state_q == T1);
    RD           = (strobe_phase && !write_q) ? STROBE_ON : STROBE_OFF;
    WR           = (strobe_phase &&  write_q) ? STROBE_ON : STROBE_OFF;
    Data_oe      = write_q && (strobe_phase || state_q == T4);
    Data_out     = Data_oe ? wdata_q : '0;
    IOM          = iom_q;
    Address      = addr_q;
    resp_valid   = (state_q == T4);
    resp_rdata   = rdata_q;
`ifdef WAIT_STATE_EN
    resp_err     = (state_q == T4) && err_q;
`else
    resp_err     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Directed self-checking bench for bus_cycle_initiator.
// Wait-state scenarios run only when WAIT_STATE_EN is defined for the build.
module tb_bus_cycle_initiator;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready, req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_err;
  logic [7:0]  resp_rdata;
  logic        ALE, RD, WR, IOM, Data_oe;
  logic [19:0] Address;
  logic [7:0]  Data_out, Data_in;
  logic        READY;

  int n_checks = 0;
  int n_fail   = 0;

  bus_cycle_initiator dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .Address(Address),
    .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in), .READY(READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol invariants sampled every cycle outside reset.
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      check("rd_wr_never_both_low", 32'(!(RD === 1'b0 && WR === 1'b0)), 1);
      check("ale_not_with_strobe", 32'(!(ALE === 1'b1 && (RD === 1'b0 || WR === 1'b0))), 1);
    end
  end

  // Called at a negedge; returns at the negedge of T1 (cycle index 1).
  task automatic accept_req(input logic wr, input logic io, input logic [19:0] addr,
                            input logic [7:0] wd, input logic hold);
    bit done = 1'b0;
    req_valid = 1'b1; req_write = wr; req_io = io; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready) begin
        @(posedge CLK);
        done = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    if (!done) check("accept_timeout", 32'(req_ready), 1);
    @(negedge CLK);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; Data_in = '0; READY = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset state
    check("rst_ale", 32'(ALE), 0);       check("rst_rd", 32'(RD), 1);
    check("rst_wr", 32'(WR), 1);         check("rst_iom", 32'(IOM), 0);
    check("rst_addr", 32'(Address), 0);  check("rst_dout", 32'(Data_out), 0);
    check("rst_oe", 32'(Data_oe), 0);    check("rst_ready", 32'(req_ready), 1);
    check("rst_rvalid", 32'(resp_valid), 0); check("rst_rdata", 32'(resp_rdata), 0);
    check("rst_err", 32'(resp_err), 0);
    RESET = 1'b0;
    @(negedge CLK);

    // 1. Memory read 0x01234 returning 0xA5
    Data_in = 8'hA5; READY = 1'b1;
    accept_req(1'b0, 1'b0, 20'h01234, 8'h00, 1'b0);
    check("r1_t1_ale", 32'(ALE), 1);       check("r1_t1_rd", 32'(RD), 1);
    check("r1_t1_iom", 32'(IOM), 1);       check("r1_t1_addr", 32'(Address), 32'h01234);
    check("r1_t1_ready", 32'(req_ready), 0);
    @(negedge CLK);
    check("r1_t2_ale", 32'(ALE), 0);       check("r1_t2_rd", 32'(RD), 0);
    check("r1_t2_wr", 32'(WR), 1);         check("r1_t2_oe", 32'(Data_oe), 0);
    @(negedge CLK);
    check("r1_t3_rd", 32'(RD), 0);         check("r1_t3_rvalid", 32'(resp_valid), 0);
    @(negedge CLK);
    check("r1_t4_rvalid", 32'(resp_valid), 1); check("r1_t4_rd", 32'(RD), 1);
    check("r1_t4_rdata", 32'(resp_rdata), 32'hA5); check("r1_t4_err", 32'(resp_err), 0);
    check("r1_t4_ready", 32'(req_ready), 1);
    @(negedge CLK);
    check("r1_idle_rvalid", 32'(resp_valid), 0);

    // 2. IO write 0x00040 data 0x3C
    accept_req(1'b1, 1'b1, 20'h00040, 8'h3C, 1'b0);
    check("w2_t1_iom", 32'(IOM), 0);       check("w2_t1_addr", 32'(Address), 32'h00040);
    check("w2_t1_oe", 32'(Data_oe), 0);    check("w2_t1_wr", 32'(WR), 1);
    @(negedge CLK);
    check("w2_t2_wr", 32'(WR), 0);         check("w2_t2_rd", 32'(RD), 1);
    check("w2_t2_oe", 32'(Data_oe), 1);    check("w2_t2_dout", 32'(Data_out), 32'h3C);
    @(negedge CLK);
    check("w2_t3_wr", 32'(WR), 0);         check("w2_t3_oe", 32'(Data_oe), 1);
    @(negedge CLK);
    check("w2_t4_wr", 32'(WR), 1);         check("w2_t4_oe", 32'(Data_oe), 1);
    check("w2_t4_dout", 32'(Data_out), 32'h3C); check("w2_t4_rvalid", 32'(resp_valid), 1);
    @(negedge CLK);
    check("w2_after_oe", 32'(Data_oe), 0); check("w2_after_rvalid", 32'(resp_valid), 0);

`ifdef WAIT_STATE_EN
    // 3. READY low for T3, TW1, TW2 -> three TW cycles, response at index 7
    READY = 1'b0; Data_in = 8'h00;
    accept_req(1'b0, 1'b0, 20'h0ABCD, 8'h00, 1'b0);
    @(negedge CLK);
    for (int k = 3; k <= 6; k++) begin
      @(negedge CLK);
      check("ws3_rd_low", 32'(RD), 0);
      check("ws3_no_rvalid", 32'(resp_valid), 0);
      if (k == 6) begin
        READY = 1'b1; Data_in = 8'hC3;
      end
    end
    @(negedge CLK);
    check("ws3_rvalid_idx7", 32'(resp_valid), 1); check("ws3_rdata", 32'(resp_rdata), 32'hC3);
    check("ws3_err", 32'(resp_err), 0);
    @(negedge CLK);

    // 4. READY held low -> 15 TW cycles then T4 with resp_err, response at index 19
    READY = 1'b0; Data_in = 8'h11;
    accept_req(1'b0, 1'b0, 20'h00200, 8'h00, 1'b0);
    @(negedge CLK);
    for (int k = 3; k <= 18; k++) begin
      @(negedge CLK);
      check("to4_rd_low", 32'(RD), 0);
      check("to4_no_rvalid", 32'(resp_valid), 0);
    end
    @(negedge CLK);
    check("to4_rvalid_idx19", 32'(resp_valid), 1); check("to4_err", 32'(resp_err), 1);
    check("to4_rd_high", 32'(RD), 1);
    @(negedge CLK);
    READY = 1'b1; Data_in = 8'h22;
    accept_req(1'b0, 1'b0, 20'h00201, 8'h00, 1'b0);
    repeat (3) @(negedge CLK);
    check("to4_next_rvalid", 32'(resp_valid), 1); check("to4_next_err", 32'(resp_err), 0);
    check("to4_next_rdata", 32'(resp_rdata), 32'h22);
    @(negedge CLK);
`else
    // 3/4. READY is ignored: READY low still completes at index 4 without error
    READY = 1'b0; Data_in = 8'h5A;
    accept_req(1'b0, 1'b0, 20'hFFFFF, 8'h00, 1'b0);
    check("nw_t1_addr", 32'(Address), 32'hFFFFF);
    @(negedge CLK);
    @(negedge CLK);
    check("nw_t3_rvalid", 32'(resp_valid), 0);
    @(negedge CLK);
    check("nw_t4_rvalid", 32'(resp_valid), 1); check("nw_t4_rdata", 32'(resp_rdata), 32'h5A);
    check("nw_t4_err", 32'(resp_err), 0);
    @(negedge CLK);
    READY = 1'b1;
`endif

    // 5. Back-to-back reads: second T1 directly after T4, ALE 4 cycles apart
    Data_in = 8'hA1;
    accept_req(1'b0, 1'b0, 20'h10000, 8'h00, 1'b1);
    check("bb_ale_idx1", 32'(ALE), 1);
    req_addr = 20'h20000;
    for (int k = 2; k <= 4; k++) begin
      @(negedge CLK);
      check("bb_ale_low", 32'(ALE), 0);
    end
    check("bb_first_rvalid", 32'(resp_valid), 1); check("bb_first_rdata", 32'(resp_rdata), 32'hA1);
    @(negedge CLK);
    req_valid = 1'b0; Data_in = 8'hB2;
    check("bb_ale_idx5", 32'(ALE), 1);     check("bb_addr2", 32'(Address), 32'h20000);
    check("bb_no_idle", 32'(req_ready), 0);
    repeat (3) @(negedge CLK);
    check("bb_second_rvalid", 32'(resp_valid), 1); check("bb_second_rdata", 32'(resp_rdata), 32'hB2);
    @(negedge CLK);
    check("bb_idle_ready", 32'(req_ready), 1); check("bb_idle_rvalid", 32'(resp_valid), 0);

    // 6. Reset during T2 of a write
    accept_req(1'b1, 1'b0, 20'h12345, 8'h77, 1'b0);
    @(negedge CLK);
    check("rs6_t2_wr", 32'(WR), 0);        check("rs6_t2_oe", 32'(Data_oe), 1);
    #2 RESET = 1'b1;
    #1;
    check("rs6_wr_high", 32'(WR), 1);      check("rs6_oe_low", 32'(Data_oe), 0);
    check("rs6_ale_low", 32'(ALE), 0);     check("rs6_rd_high", 32'(RD), 1);
    check("rs6_addr_clr", 32'(Address), 0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("rs6_no_rvalid", 32'(resp_valid), 0);
    end
    check("rs6_ready", 32'(req_ready), 1);
    check("rs6_strobes_off", 32'({RD, WR}), 32'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
